// File: rtl/baud_gen.sv
// ---------------------------------------------------------------------------
// baud_gen
//
// Baud-rate tick generator for a UART. A 4-bit rate code selects one of
// twelve standard rates; the matching divisors are worked out at elaboration
// time from CLK_HZ and OVERSAMPLE, so no divider is built in hardware.
//
// Two free-running counters derive the ticks:
//   tx counter : divisor k,  one tx_tick per bit period
//   os counter : divisor ko, OVERSAMPLE os_ticks per bit period
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   en        in   tick enable, counters hold while low
//   baud_val  in   requested rate code (0..11 legal)
//   ld        in   strobe: load baud_val as the active code
//   resync    in   strobe: restart the oversample counter
//   tx_tick   out  one-cycle pulse per bit period
//   os_tick   out  one-cycle pulse per oversample period
//   k         out  active bit-period divisor (0 when invalid)
//   valid     out  active code is legal and ticks may run
// ---------------------------------------------------------------------------
module baud_gen #(
    parameter int         CLK_HZ     = 100_000_000,
    parameter int         OVERSAMPLE = 16,
    parameter int         CNT_W      = 19,
    parameter logic [3:0] RESET_BAUD = 4'b0100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       baud_val,
    input  logic             ld,
    input  logic             resync,
    output logic             tx_tick,
    output logic             os_tick,
    output logic [CNT_W-1:0] k,
    output logic             valid
);

    localparam logic [63:0]      CLK64   = 64'(CLK_HZ);
    localparam logic [63:0]      OS64    = 64'(OVERSAMPLE);
    localparam logic [63:0]      CNT_LIM = 64'd1 << CNT_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Baud rate for each code; unused codes return 0 so they come out invalid.
    function automatic logic [63:0] rate_of(input int code);
        case (code)
            0:       return 64'd300;
            1:       return 64'd1200;
            2:       return 64'd2400;
            3:       return 64'd4800;
            4:       return 64'd9600;
            5:       return 64'd19200;
            6:       return 64'd38400;
            7:       return 64'd57600;
            8:       return 64'd115200;
            9:       return 64'd230400;
            10:      return 64'd460800;
            11:      return 64'd921600;
            default: return 64'd0;
        endcase
    endfunction

    // Round-to-nearest integer division; a zero denominator yields 0.
    function automatic logic [63:0] round_div(input logic [63:0] num,
                                              input logic [63:0] den);
        if (den == 64'd0) begin
            return 64'd0;
        end
        return (num + (den >> 1)) / den;
    endfunction

    // Divisor and legality lookup tables, all constants after elaboration.
    logic [CNT_W-1:0] k_tab  [16];
    logic [CNT_W-1:0] ko_tab [16];
    logic             ok_tab [16];

    for (genvar i = 0; i < 16; i++) begin : g_rate
        localparam logic [63:0] KV  = round_div(CLK64, rate_of(i));
        localparam logic [63:0] KOV = round_div(CLK64, rate_of(i) * OS64);
        localparam bit          OK  = (i < 12) && (KV >= 64'd2) &&
                                      (KOV >= 64'd2) && (KV < CNT_LIM);
        assign ok_tab[i] = OK;
        assign k_tab[i]  = OK ? KV[CNT_W-1:0]  : '0;
        assign ko_tab[i] = OK ? KOV[CNT_W-1:0] : '0;
    end

    logic [3:0]       code;
    logic [CNT_W-1:0] ko;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] os_cnt;
    logic             run;

    assign k     = k_tab[code];
    assign ko    = ko_tab[code];
    assign valid = ok_tab[code];
    assign run   = en && valid;

    // Active code register and tx counter. Priority is reset, then ld, then
    // normal counting; ld discards any tick that would have been due.
    always_ff @(posedge clk) begin
        if (reset) begin
            code    <= RESET_BAUD;
            tx_cnt  <= '0;
            tx_tick <= 1'b0;
        end else if (ld) begin
            code    <= baud_val;
            tx_cnt  <= '0;
            tx_tick <= 1'b0;
        end else if (run) begin
            if (tx_cnt == k - CNT_ONE) begin
                tx_cnt  <= '0;
                tx_tick <= 1'b1;
            end else begin
                tx_cnt  <= tx_cnt + CNT_ONE;
                tx_tick <= 1'b0;
            end
        end else begin
            tx_tick <= 1'b0;
        end
    end

    // Oversample counter. resync restarts it for start-bit alignment and
    // swallows any tick due in that cycle; ld still wins over resync.
    always_ff @(posedge clk) begin
        if (reset || ld || resync) begin
            os_cnt  <= '0;
            os_tick <= 1'b0;
        end else if (run) begin
            if (os_cnt == ko - CNT_ONE) begin
                os_cnt  <= '0;
                os_tick <= 1'b1;
            end else begin
                os_cnt  <= os_cnt + CNT_ONE;
                os_tick <= 1'b0;
            end
        end else begin
            os_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_gen.sv
// ---------------------------------------------------------------------------
// tb_baud_gen
//
// Directed testbench for baud_gen at default parameters. Each task drives
// one scenario and compares observed tick positions and divisor outputs
// against hand-computed values. Cycle numbers count rising edges from the
// edge that sampled the triggering event (reset release, ld, resync).
// ---------------------------------------------------------------------------
module tb_baud_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  baud_val;
    logic        ld;
    logic        resync;
    logic        tx_tick;
    logic        os_tick;
    logic [18:0] k;
    logic        valid;

    int errors = 0;
    int checks = 0;

    baud_gen dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .baud_val (baud_val),
        .ld       (ld),
        .resync   (resync),
        .tx_tick  (tx_tick),
        .os_tick  (os_tick),
        .k        (k),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are read 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until tx_tick is seen or the budget runs out.
    task automatic wait_tx(input int limit, output bit found);
        int n = 0;
        found = 1'b0;
        while (n < limit && !found) begin
            step();
            n++;
            if (tx_tick) found = 1'b1;
        end
    endtask

    // Record positions of the first tx and os ticks after the current edge.
    task automatic measure(input int limit, input int ntx, input logic [18:0] expk,
                           output int tx1, output int tx2, output int os1,
                           output int os2, output bit kbad);
        int n = 0;
        tx1 = -1; tx2 = -1; os1 = -1; os2 = -1; kbad = 1'b0;
        while (n < limit && !((ntx == 1 && tx1 >= 0) || tx2 >= 0)) begin
            step();
            n++;
            if (k !== expk || valid !== 1'b1) kbad = 1'b1;
            if (tx_tick) begin
                if (tx1 < 0) tx1 = n;
                else if (tx2 < 0) tx2 = n;
            end
            if (os_tick) begin
                if (os1 < 0) os1 = n;
                else if (os2 < 0) os2 = n;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; ld = 1'b1; baud_val = 4'd11; resync = 1'b1;
        step(); step(); step();
        checks++; if (k !== 19'd10417) begin errors++; $display("[TB] FAIL reset_k: got %0d expected 10417", k); end
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_valid: got %0d expected 1", valid); end
        checks++; if (tx_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_tick: got %0d expected 0", tx_tick); end
        checks++; if (os_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_os_tick: got %0d expected 0", os_tick); end
        ld = 1'b0; resync = 1'b0;
        step();
    endtask

    task automatic test_default();
        int tx1, tx2, os1, os2;
        bit kbad;
        reset = 1'b0;
        measure(21000, 2, 19'd10417, tx1, tx2, os1, os2, kbad);
        checks++; if (tx1 !== 10417) begin errors++; $display("[TB] FAIL default_first_tx: got %0d expected 10417", tx1); end
        checks++; if (tx2 - tx1 !== 10417) begin errors++; $display("[TB] FAIL default_tx_period: got %0d expected 10417", tx2 - tx1); end
        checks++; if (os1 !== 651) begin errors++; $display("[TB] FAIL default_first_os: got %0d expected 651", os1); end
        checks++; if (os2 - os1 !== 651) begin errors++; $display("[TB] FAIL default_os_period: got %0d expected 651", os2 - os1); end
        checks++; if (kbad !== 1'b0) begin errors++; $display("[TB] FAIL default_k_steady: got %0d expected 0", kbad); end
    endtask

    task automatic test_fast_ld();
        int tx1, tx2, os1, os2;
        bit kbad;
        for (int i = 0; i < 100; i++) step();
        ld = 1'b1; baud_val = 4'd11;
        step();
        ld = 1'b0;
        checks++; if (k !== 19'd109) begin errors++; $display("[TB] FAIL fast_ld_k: got %0d expected 109", k); end
        checks++; if (tx_tick !== 1'b0) begin errors++; $display("[TB] FAIL fast_ld_tx_tick: got %0d expected 0", tx_tick); end
        measure(300, 2, 19'd109, tx1, tx2, os1, os2, kbad);
        checks++; if (tx1 !== 109) begin errors++; $display("[TB] FAIL fast_first_tx: got %0d expected 109", tx1); end
        checks++; if (tx2 - tx1 !== 109) begin errors++; $display("[TB] FAIL fast_tx_period: got %0d expected 109", tx2 - tx1); end
        checks++; if (os1 !== 7) begin errors++; $display("[TB] FAIL fast_first_os: got %0d expected 7", os1); end
        checks++; if (os2 - os1 !== 7) begin errors++; $display("[TB] FAIL fast_os_period: got %0d expected 7", os2 - os1); end
    endtask

    task automatic test_invalid();
        int tx1, tx2, os1, os2, nticks;
        bit kbad, kmoved;
        ld = 1'b1; baud_val = 4'd13;
        step();
        ld = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL invalid_valid: got %0d expected 0", valid); end
        checks++; if (k !== 19'd0) begin errors++; $display("[TB] FAIL invalid_k: got %0d expected 0", k); end
        nticks = 0; kmoved = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (tx_tick || os_tick) nticks++;
            if (k !== 19'd0 || valid !== 1'b0) kmoved = 1'b1;
        end
        checks++; if (nticks !== 0) begin errors++; $display("[TB] FAIL invalid_ticks: got %0d expected 0", nticks); end
        checks++; if (kmoved !== 1'b0) begin errors++; $display("[TB] FAIL invalid_hold: got %0d expected 0", kmoved); end
        ld = 1'b1; baud_val = 4'd10;
        step();
        ld = 1'b0;
        checks++; if (k !== 19'd217) begin errors++; $display("[TB] FAIL restore_k: got %0d expected 217", k); end
        measure(600, 2, 19'd217, tx1, tx2, os1, os2, kbad);
        checks++; if (tx1 !== 217) begin errors++; $display("[TB] FAIL restore_first_tx: got %0d expected 217", tx1); end
        checks++; if (tx2 - tx1 !== 217) begin errors++; $display("[TB] FAIL restore_tx_period: got %0d expected 217", tx2 - tx1); end
        checks++; if (os1 !== 14) begin errors++; $display("[TB] FAIL restore_first_os: got %0d expected 14", os1); end
        checks++; if (os2 - os1 !== 14) begin errors++; $display("[TB] FAIL restore_os_period: got %0d expected 14", os2 - os1); end
    endtask

    // Code 10 active. First resync 5 cycles after an os_tick, second resync
    // exactly when a tick is due, to show it is swallowed.
    task automatic test_resync();
        int n, os_at, os2, os3, tx_n;
        bit found, due_tick;
        wait_tx(250, found);
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL resync_align: got %0d expected 1", found); end
        n = 0; os_at = -1; os2 = -1; os3 = -1; tx_n = -1; due_tick = 1'b0;
        while (n < 300 && tx_n < 0) begin
            resync = (os_at >= 0 && n + 1 == os_at + 5) ||
                     (os2 >= 0 && n + 1 == os2 + 14);
            step();
            n++;
            if (os2 >= 0 && n == os2 + 14) due_tick = os_tick;
            if (os_tick) begin
                if (os_at < 0) os_at = n;
                else if (os2 < 0 && n > os_at + 5) os2 = n;
                else if (os3 < 0 && os2 >= 0 && n > os2 + 14) os3 = n;
            end
            if (tx_tick) tx_n = n;
        end
        resync = 1'b0;
        checks++; if (os2 - (os_at + 5) !== 14) begin errors++; $display("[TB] FAIL resync_next_os: got %0d expected 14", os2 - (os_at + 5)); end
        checks++; if (due_tick !== 1'b0) begin errors++; $display("[TB] FAIL resync_suppress: got %0d expected 0", due_tick); end
        checks++; if (os3 - os2 !== 28) begin errors++; $display("[TB] FAIL resync_after_suppress: got %0d expected 28", os3 - os2); end
        checks++; if (tx_n !== 217) begin errors++; $display("[TB] FAIL resync_tx_period: got %0d expected 217", tx_n); end
    endtask

    // Code 11, en low for 50 cycles starting 20 cycles into a bit period.
    task automatic test_en_pause();
        int n;
        bit found, done, quiet_bad;
        ld = 1'b1; baud_val = 4'd11;
        step();
        ld = 1'b0;
        wait_tx(120, found);
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL pause_align: got %0d expected 1", found); end
        n = 0; done = 1'b0; quiet_bad = 1'b0;
        while (!done && n < 400) begin
            en = !(n >= 20 && n < 70);
            step();
            n++;
            if (!en && (tx_tick || os_tick)) quiet_bad = 1'b1;
            if (tx_tick) done = 1'b1;
        end
        en = 1'b1;
        checks++; if (n !== 159) begin errors++; $display("[TB] FAIL pause_tx_interval: got %0d expected 159", n); end
        checks++; if (quiet_bad !== 1'b0) begin errors++; $display("[TB] FAIL pause_quiet: got %0d expected 0", quiet_bad); end
    endtask

    // Starts right after a tx_tick at code 11; ld lands on the terminal count.
    task automatic test_ld_terminal();
        int tx1, tx2, os1, os2;
        bit kbad;
        for (int i = 0; i < 108; i++) step();
        ld = 1'b1; baud_val = 4'd11;
        step();
        ld = 1'b0;
        checks++; if (tx_tick !== 1'b0) begin errors++; $display("[TB] FAIL ld_term_tx_tick: got %0d expected 0", tx_tick); end
        checks++; if (os_tick !== 1'b0) begin errors++; $display("[TB] FAIL ld_term_os_tick: got %0d expected 0", os_tick); end
        checks++; if (k !== 19'd109) begin errors++; $display("[TB] FAIL ld_term_k: got %0d expected 109", k); end
        measure(300, 2, 19'd109, tx1, tx2, os1, os2, kbad);
        checks++; if (tx1 !== 109) begin errors++; $display("[TB] FAIL ld_term_first_tx: got %0d expected 109", tx1); end
        checks++; if (os1 !== 7) begin errors++; $display("[TB] FAIL ld_term_first_os: got %0d expected 7", os1); end
        checks++; if (kbad !== 1'b0) begin errors++; $display("[TB] FAIL ld_term_k_steady: got %0d expected 0", kbad); end
    endtask

    // Starts right after a tx_tick at code 11; reset lands on the terminal count.
    task automatic test_reset_mid();
        int tx1, tx2, os1, os2;
        bit kbad;
        for (int i = 0; i < 108; i++) step();
        reset = 1'b1;
        step();
        checks++; if (tx_tick !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_tx_tick: got %0d expected 0", tx_tick); end
        checks++; if (k !== 19'd10417) begin errors++; $display("[TB] FAIL rst_mid_k: got %0d expected 10417", k); end
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_valid: got %0d expected 1", valid); end
        reset = 1'b0;
        measure(10500, 1, 19'd10417, tx1, tx2, os1, os2, kbad);
        checks++; if (tx1 !== 10417) begin errors++; $display("[TB] FAIL rst_mid_first_tx: got %0d expected 10417", tx1); end
        checks++; if (os1 !== 651) begin errors++; $display("[TB] FAIL rst_mid_first_os: got %0d expected 651", os1); end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; baud_val = 4'd0; ld = 1'b0; resync = 1'b0;
        test_reset();
        test_default();
        test_fast_ld();
        test_invalid();
        test_resync();
        test_en_pause();
        test_ld_terminal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
